uart_rx_os16: RTL and testbench

//  Standalone 8-bit UART receiver with 16x oversampling and majority-vote bit decisions.

---
 rtl/uart_rx_os16.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8-bit UART receiver: 2-flop synchronizer, 16x oversampling, 2-of-3 majority bit decisions.
// Optional macro UART_RX_PARITY_EN adds a parity bit (sense set by PARITY_ODD) before the stop bit.
module uart_rx_os16 #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rxIn,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] rxOut
);

    localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(DIV - 1);
    localparam logic [SCW-1:0] SAMP_LO   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SAMP_HI   = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [TCW-1:0]   tick_q, tick_d;
    logic [SCW-1:0]   samp_q, samp_d;
    logic [2:0]       vote_q, vote_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_q, out_d;
    logic             busy_q, done_q, done_d, err_q, err_d;
    logic             tick_s, sample_s, bit_end_s, maj_s, par_fault_s;
    logic [2:0]       vote_next_s;

`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    assign par_fault_s = ((^shift_q) ^ par_q) != PARITY_ODD[0];
`else
    assign par_fault_s = 1'b0;
`endif

    assign tick_s      = (tick_q == TICK_LAST);
    assign sample_s    = tick_s && (samp_q >= SAMP_LO) && (samp_q <= SAMP_HI);
    assign bit_end_s   = tick_s && (samp_q == SAMP_LAST);
    // Majority includes the sample taken this cycle so the early false-start check sees all three
    assign vote_next_s = sample_s ? {vote_q[1:0], sync2_q} : vote_q;
    assign maj_s       = maj3(vote_next_s);

    // Next-state, datapath and strobe logic
    always_comb begin
        state_d = state_q;
        vote_d  = vote_next_s;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == S_IDLE) begin
            tick_d = {TCW{1'b0}};
            samp_d = {SCW{1'b0}};
        end else if (tick_s) begin
            tick_d = {TCW{1'b0}};
            samp_d = (samp_q == SAMP_LAST) ? {SCW{1'b0}} : samp_q + {{(SCW-1){1'b0}}, 1'b1};
        end else begin
            tick_d = tick_q + {{(TCW-1){1'b0}}, 1'b1};
            samp_d = samp_q;
        end

        if ((state_q != S_IDLE) && !rxEn) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rxEn && !sync2_q) begin
                        state_d = S_START;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (sample_s && (samp_q == SAMP_HI) && maj_s) begin
                        state_d = S_IDLE;
                    end else if (bit_end_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        shift_d = {maj_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        state_d = (bit_q == 3'd7) ? S_PARITY : S_DATA;
`else
                        state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end_s) begin
                        par_d   = maj_s;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
`endif
                S_STOP: begin
                    if (!bit_end_s) begin
                        state_d = S_STOP;
                    end else if (!maj_s) begin
                        err_d   = 1'b1;
                        state_d = S_WAIT;
                    end else if (par_fault_s) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        out_d   = shift_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (sync2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, synchronizer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tick_q  <= {TCW{1'b0}};
            samp_q  <= {SCW{1'b0}};
            vote_q  <= 3'b000;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            out_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= rxIn;
            sync2_q <= sync1_q;
            tick_q  <= tick_d;
            samp_q  <= samp_d;
            vote_q  <= vote_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rxBusy = busy_q;
    assign rxDone = done_q;
    assign rxErr  = err_q;
    assign rxOut  = out_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16; received bytes are matched against a scoreboard queue.
module tb_uart_rx_os16;

    localparam int DIV      = 8;
    localparam int OS       = 16;
    localparam int BAUD     = 9600;
    localparam int CLK_RATE = BAUD * OS * DIV;
    localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxEn = 1'b0;
    logic       rxIn = 1'b1;
    logic       rxBusy, rxDone, rxErr;
    logic [7:0] rxOut;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int frame_start = 0;
    int busy_lat = -1;
    logic [7:0] exp_q[$];

    uart_rx_os16 #(
        .CLOCK_RATE(CLK_RATE),
        .BAUD_RATE (BAUD),
        .OVERSAMPLE(OS),
        .PARITY_ODD(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rxEn  (rxEn),
        .rxIn  (rxIn),
        .rxBusy(rxBusy),
        .rxDone(rxDone),
        .rxErr (rxErr),
        .rxOut (rxOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int got, input int lo, input int hi);
        total++;
        assert (got >= lo && got <= hi) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=[%0d..%0d]", tag, got, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_cycles,
                              input logic par_flip);
        frame_start = cyc;
        busy_lat = -1;
        rxIn = 1'b0;
        for (int c = 0; c < BIT; c++) begin
            @(negedge clk);
            if (busy_lat < 0 && rxBusy) busy_lat = c + 1;
        end
        for (int i = 0; i < 8; i++) begin
            rxIn = d[i];
            wait_clk(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rxIn = (^d) ^ par_flip;
        wait_clk(BIT);
`else
        if (par_flip) rxIn = 1'b1;
`endif
        rxIn = stop_v;
        wait_clk(stop_cycles);
        rxIn = 1'b1;
    endtask

    // Output monitor: scoreboard pop on rxDone, pulse exclusivity on any strobe
    always @(negedge clk) begin
        if (!reset) begin
            if (rxDone || rxErr) check_eq("done_err_exclusive", {31'd0, rxDone && rxErr}, 32'd0);
            if (rxErr) err_cnt++;
            if (rxDone) begin
                done_cnt++;
                last_done_cyc = cyc;
                check_eq("sb_nonempty_on_done", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check_eq("sb_byte", {24'd0, rxOut}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int d0, e0, t0, fall;
        logic [7:0] ab;

        // Reset values
        reset = 1'b1; rxEn = 1'b0; rxIn = 1'b1;
        wait_clk(3);
        check_eq("rst_busy", {31'd0, rxBusy}, 32'd0);
        check_eq("rst_done", {31'd0, rxDone}, 32'd0);
        check_eq("rst_err",  {31'd0, rxErr},  32'd0);
        check_eq("rst_out",  {24'd0, rxOut},  32'd0);
        reset = 1'b0; rxEn = 1'b1;
        wait_clk(4);

        // 1: single good frame, busy latency and done latency
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b1, BIT, 1'b0);
        wait_clk(8);
        check_rng("t1_busy_lat", busy_lat, 2, 3);
        check_eq("t1_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t1_err_cnt", err_cnt - e0, 32'd0);
        check_rng("t1_done_lat", last_done_cyc - frame_start, FRAME_BITS * BIT + 1, FRAME_BITS * BIT + 5);
        check_eq("t1_out", {24'd0, rxOut}, 32'h45);

        // 2: short low glitch is a false start, rejected at the third mid-bit sample
        d0 = done_cnt; e0 = err_cnt;
        t0 = cyc; fall = -1;
        rxIn = 1'b0;
        wait_clk(BIT / 4);
        rxIn = 1'b1;
        for (int c = 0; c < 4 * BIT && fall < 0; c++) begin
            @(negedge clk);
            if (!rxBusy) fall = cyc - t0;
        end
        check_rng("t2_busy_fall", fall, 10 * DIV + 1, 10 * DIV + 5);
        wait_clk(2 * BIT);
        check_eq("t2_done_cnt", done_cnt - d0, 32'd0);
        check_eq("t2_err_cnt", err_cnt - e0, 32'd0);

        // 3: framing error with the line held low afterwards
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 3 * BIT, 1'b0);
        check_eq("t3_busy_in_break", {31'd0, rxBusy}, 32'd1);
        t0 = cyc; fall = -1;
        for (int c = 0; c < 16 && fall < 0; c++) begin
            @(negedge clk);
            if (!rxBusy) fall = cyc - t0;
        end
        check_rng("t3_busy_release", fall, 2, 4);
        check_eq("t3_err_cnt", err_cnt - e0, 32'd1);
        check_eq("t3_done_cnt", done_cnt - d0, 32'd0);
        check_eq("t3_out_kept", {24'd0, rxOut}, 32'h45);
        wait_clk(BIT);

        // 4: drop rxEn in data bit 4, then recover
        d0 = done_cnt; e0 = err_cnt;
        ab = 8'h96;
        rxIn = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rxIn = ab[i];
            wait_clk(BIT);
        end
        rxIn = ab[4];
        wait_clk(BIT / 2);
        rxEn = 1'b0; rxIn = 1'b1;
        wait_clk(1);
        check_eq("t4_busy_abort", {31'd0, rxBusy}, 32'd0);
        wait_clk(2 * BIT);
        check_eq("t4_no_done", done_cnt - d0, 32'd0);
        check_eq("t4_no_err", err_cnt - e0, 32'd0);
        rxEn = 1'b1;
        wait_clk(4);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, BIT, 1'b0);
        wait_clk(8);
        check_eq("t4_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t4_out", {24'd0, rxOut}, 32'h3C);

        // 5: back-to-back frames with a single stop bit
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, BIT, 1'b0);
        send_frame(8'hFF, 1'b1, BIT, 1'b0);
        wait_clk(8);
        check_eq("t5_done_cnt", done_cnt - d0, 32'd2);
        check_eq("t5_err_cnt", err_cnt - e0, 32'd0);
        check_eq("t5_out", {24'd0, rxOut}, 32'hFF);

        // 6: reset mid-frame, then a clean frame
        rxIn = 1'b0;
        wait_clk(BIT);
        rxIn = 1'b1;
        wait_clk(BIT / 2);
        reset = 1'b1;
        wait_clk(1);
        check_eq("t6_rst_busy", {31'd0, rxBusy}, 32'd0);
        check_eq("t6_rst_done", {31'd0, rxDone}, 32'd0);
        check_eq("t6_rst_err",  {31'd0, rxErr},  32'd0);
        check_eq("t6_rst_out",  {24'd0, rxOut},  32'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(4);
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BIT, 1'b0);
        wait_clk(8);
        check_eq("t6_done_cnt", done_cnt - d0, 32'd1);
        check_eq("t6_out", {24'd0, rxOut}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // 7: parity good then parity bad
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b1, BIT, 1'b0);
        wait_clk(8);
        check_eq("t7_good_done", done_cnt - d0, 32'd1);
        check_eq("t7_good_out", {24'd0, rxOut}, 32'h45);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h45, 1'b1, BIT, 1'b1);
        wait_clk(8);
        check_eq("t7_bad_err", err_cnt - e0, 32'd1);
        check_eq("t7_bad_done", done_cnt - d0, 32'd0);
        check_eq("t7_bad_out", {24'd0, rxOut}, 32'h45);
        check_eq("t7_bad_idle", {31'd0, rxBusy}, 32'd0);
`endif

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
